// File: rtl/kernel_buffer_loader.sv
// Streams kernel weights into the kernel buffer, round-robin across banks, one row per D beats.
// Holds the buffer in IO mode for the whole load, then hands it back to compute and pulses done.
//
// state | meaning
// IDLE  | buffer in compute mode, waiting for start
// LOAD  | accepting weights, ioSelect held high
// DRAIN | last write on the bus, done follows
module kernel_buffer_loader #(
    parameter int depth = 2,
    parameter int A     = 7,
    parameter int W     = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic [A-1:0]       baseAddr,
    input  logic [A:0]         rowCount,
    input  logic               abort,
    input  logic [W-1:0]       wData,
    input  logic               wValid,
    output logic               wReady,
    output logic [W+depth+1:0] ioInputs,
    output logic [A-1:0]       address,
    output logic               busy,
    output logic               done
);

    localparam int D = 1 << depth;
    localparam logic [depth-1:0] BANK_LAST = depth'(D - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [A-1:0]       base_q;
    logic [A:0]         rows_q;
    logic [depth-1:0]   bank_cnt;
    logic [A:0]         row_cnt;
    logic               io_write_q;
    logic [depth-1:0]   io_bank_q;
    logic [W-1:0]       io_data_q;
    logic [A-1:0]       addr_q;
    logic               done_q;

    logic               accept;
    logic               last_beat;
    logic               load_start;
    logic               write_nxt;
    logic               done_nxt;

    assign accept    = wValid && (state == LOAD);
    assign last_beat = accept && (bank_cnt == BANK_LAST) && (row_cnt == rows_q - 1'b1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && (rowCount != '0)) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // An accepted beat in the abort cycle is dropped on purpose.
    always_comb begin
        load_start = 1'b0;
        write_nxt  = 1'b0;
        done_nxt   = 1'b0;
        wReady     = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                load_start = start && (rowCount != '0);
                done_nxt   = start && (rowCount == '0);
            end
            LOAD: begin
                wReady    = 1'b1;
                busy      = 1'b1;
                write_nxt = accept && !abort;
            end
            DRAIN: begin
                busy     = 1'b1;
                done_nxt = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            base_q     <= '0;
            rows_q     <= '0;
            bank_cnt   <= '0;
            row_cnt    <= '0;
            io_write_q <= 1'b0;
            io_bank_q  <= '0;
            io_data_q  <= '0;
            addr_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            io_write_q <= write_nxt;
            done_q     <= done_nxt;
            if (load_start) begin
                base_q   <= baseAddr;
                rows_q   <= rowCount;
                bank_cnt <= '0;
                row_cnt  <= '0;
                addr_q   <= baseAddr;
            end
            if (write_nxt) begin
                io_bank_q <= bank_cnt;
                io_data_q <= wData;
                addr_q    <= base_q + row_cnt[A-1:0];
                bank_cnt  <= bank_cnt + 1'b1;
                if (bank_cnt == BANK_LAST) begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end
        end
    end

    assign ioInputs = {busy, io_write_q, io_bank_q, io_data_q};
    assign address  = addr_q;
    assign done     = done_q;

endmodule

// File: tb/tb_kernel_buffer_loader.sv
// Self-checking bench for kernel_buffer_loader: table of load scenarios plus hand-written
// sequences for start/abort priority and asynchronous reset in the middle of a load.
module tb_kernel_buffer_loader;

    localparam int DEPTH = 2;
    localparam int AW    = 7;
    localparam int WW    = 16;
    localparam int NB    = 1 << DEPTH;

    logic              CLK;
    logic              RST_N;
    logic              start;
    logic [AW-1:0]     baseAddr;
    logic [AW:0]       rowCount;
    logic              abort;
    logic [WW-1:0]     wData;
    logic              wValid;
    logic              wReady;
    logic [WW+DEPTH+1:0] ioInputs;
    logic [AW-1:0]     address;
    logic              busy;
    logic              done;

    kernel_buffer_loader #(.depth(DEPTH), .A(AW), .W(WW)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .baseAddr (baseAddr),
        .rowCount (rowCount),
        .abort    (abort),
        .wData    (wData),
        .wValid   (wValid),
        .wReady   (wReady),
        .ioInputs (ioInputs),
        .address  (address),
        .busy     (busy),
        .done     (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    wire            io_sel  = ioInputs[WW+DEPTH+1];
    wire            io_wr   = ioInputs[WW+DEPTH];
    wire [DEPTH-1:0] io_bank = ioInputs[WW+DEPTH-1:WW];
    wire [WW-1:0]   io_data = ioInputs[WW-1:0];

    typedef struct {
        logic [DEPTH-1:0] bank;
        logic [WW-1:0]    data;
        logic [AW-1:0]    addr;
    } wr_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   rows;
        bit            stall;
        int            abort_after;
        int            exp_writes;
        bit            exp_done;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_load(input vec_t v);
        int   writes = 0;
        int   acc = 0;
        int   bank = 0;
        int   row = 0;
        bit   fin = 0;
        bit   done_seen = 0;
        wr_t  prev;
        wr_t  e;
        wr_t  got;
        prev = '{bank: '0, data: '0, addr: '0};
        baseAddr = v.base;
        rowCount = v.rows;
        start    = 1'b1;
        tick();
        start = 1'b0;
        if (v.rows == 0) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            check("zero_sel", io_sel, 0);
            check("zero_wr", io_wr, 0);
            done_seen = done;
            tick();
            check("zero_done_once", done, 0);
            check("zero_busy_after", busy, 0);
            fin = 1;
        end else begin
            check("sel_after_start", io_sel, 1);
            check("wr_after_start", io_wr, 0);
            check("busy_after_start", busy, 1);
        end
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            bit vld;
            bit ab;
            bit exp_wr;
            bit last;
            vld  = v.stall ? (cyc % 2 == 0) : 1'b1;
            ab   = (v.abort_after >= 0) && (acc == v.abort_after);
            last = 1'b0;
            wValid = vld;
            abort  = ab;
            wData  = WW'(acc + 1);
            start  = v.stall && !vld;
            if (start) begin
                baseAddr = 7'h55;
                rowCount = 8'd1;
            end
            check("wready_load", wReady, 1);
            exp_wr = vld && !ab;
            if (exp_wr) begin
                e.bank = DEPTH'(bank);
                e.data = WW'(acc + 1);
                e.addr = v.base + AW'(row);
                sb.push_back(e);
                last = (bank == NB - 1) && (row == int'(v.rows) - 1);
                acc++;
                bank++;
                if (bank == NB) begin
                    bank = 0;
                    row++;
                end
            end
            tick();
            wValid = 1'b0;
            abort  = 1'b0;
            start  = 1'b0;
            if (exp_wr) begin
                check("write_strobe", io_wr, 1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check("write_bank", io_bank, got.bank);
                    check("write_data", io_data, got.data);
                    check("write_addr", address, got.addr);
                    prev = got;
                end
                writes++;
            end else begin
                check("no_write_stall", io_wr, 0);
                if (writes > 0) begin
                    check("hold_bank", io_bank, prev.bank);
                    check("hold_addr", address, prev.addr);
                end
            end
            check("no_early_done", done, 0);
            if (ab) begin
                check("abort_sel", io_sel, 0);
                check("abort_busy", busy, 0);
                tick();
                check("abort_no_done", done, 0);
                fin = 1;
            end else if (last) begin
                check("drain_sel", io_sel, 1);
                check("drain_busy", busy, 1);
                tick();
                check("done_pulse", done, 1);
                check("done_wr", io_wr, 0);
                check("done_sel", io_sel, 0);
                check("done_busy", busy, 0);
                check("done_addr_hold", address, prev.addr);
                done_seen = done;
                tick();
                check("done_once", done, 0);
                fin = 1;
            end
        end
        check("load_finished", fin, 1);
        check("write_count", writes, v.exp_writes);
        check("done_seen", done_seen, v.exp_done);
        check("scoreboard_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{base: 7'd0,   rows: 8'd2, stall: 0, abort_after: -1, exp_writes: 8,  exp_done: 1};
        vecs[1] = '{base: 7'd0,   rows: 8'd2, stall: 1, abort_after: -1, exp_writes: 8,  exp_done: 1};
        vecs[2] = '{base: 7'd127, rows: 8'd2, stall: 0, abort_after: -1, exp_writes: 8,  exp_done: 1};
        vecs[3] = '{base: 7'd126, rows: 8'd3, stall: 1, abort_after: -1, exp_writes: 12, exp_done: 1};
        vecs[4] = '{base: 7'd5,   rows: 8'd0, stall: 0, abort_after: -1, exp_writes: 0,  exp_done: 1};
        vecs[5] = '{base: 7'd10,  rows: 8'd2, stall: 0, abort_after: 5,  exp_writes: 5,  exp_done: 0};
        vecs[6] = '{base: 7'd20,  rows: 8'd1, stall: 0, abort_after: -1, exp_writes: 4,  exp_done: 1};

        RST_N    = 1'b0;
        start    = 1'b0;
        baseAddr = '0;
        rowCount = '0;
        abort    = 1'b0;
        wData    = '0;
        wValid   = 1'b0;
        #12;
        check("reset_io", ioInputs, 0);
        check("reset_addr", address, 0);
        check("reset_ready", wReady, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        RST_N = 1'b1;
        tick();

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_ignored", busy, 0);
        check("idle_abort_no_done", done, 0);

        for (int i = 0; i < 7; i++) begin
            run_load(vecs[i]);
        end

        baseAddr = 7'd9;
        rowCount = 8'd1;
        start    = 1'b1;
        abort    = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_beats_abort", busy, 1);
        check("start_beats_abort_sel", io_sel, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_busy", busy, 0);

        baseAddr = 7'd3;
        rowCount = 8'd2;
        start    = 1'b1;
        tick();
        start  = 1'b0;
        wValid = 1'b1;
        wData  = 16'hABCD;
        tick();
        tick();
        tick();
        check("mid_load_busy", busy, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_io", ioInputs, 0);
        check("async_rst_addr", address, 0);
        check("async_rst_ready", wReady, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        wValid = 1'b0;
        #4;
        RST_N = 1'b1;
        tick();
        tick();
        check("post_rst_ready", wReady, 0);
        check("post_rst_busy", busy, 0);

        run_load(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
